// File: rtl/iq_drive_gen.sv
// Interleaved I/Q drive source: local-bus I/Q targets are slew-limited, pulse-gated by a
// small FSM and emitted as a time-multiplexed 18-bit drive word with its I/Q slot flag.
module iq_drive_gen #(
    parameter logic [14:0] BASE_ADDR = 15'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lb_data,
    input  logic [14:0] lb_addr,
    input  logic        lb_write,
    output logic        iq,
    output logic [17:0] drive,
    output logic [1:0]  state,
    output logic        busy
);

    localparam int unsigned DW   = 18;
    localparam int unsigned SW   = 16;
    localparam int unsigned CW   = 24;
    localparam int unsigned NREG = 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            iq_q, iq_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   drive_q, drive_d;
    logic [DW-1:0]   cur_i_q, cur_i_d;
    logic [DW-1:0]   cur_q_q, cur_q_d;
    logic [DW-1:0]   tgt_i_q, tgt_i_d;
    logic [DW-1:0]   tgt_q_q, tgt_q_d;
    logic [SW-1:0]   slew_q, slew_d;
    logic [CW-1:0]   plen_q, plen_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            trig_q, trig_d;

    logic [NREG-1:0] wr_sel;
    logic            tick;
    logic            run;
    logic            trig_set;
    logic            at_tgt;
    logic            at_zero;
    logic [DW-1:0]   goal_i;
    logic [DW-1:0]   goal_q;
    logic            unused_lb;

    assign unused_lb = ^lb_data[31:24];

    // Fold -2^17 onto -(2^17-1) so every target has a representable negation.
    function automatic logic [DW-1:0] sym_clip(input logic [DW-1:0] v);
        logic [DW-1:0] most_neg;
        most_neg = {1'b1, {(DW-1){1'b0}}};
        return (v == most_neg) ? (most_neg + DW'(1)) : v;
    endfunction

    // One slew-limited step of cur toward goal; never overshoots.
    function automatic logic [DW-1:0] slew_step(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] goal,
                                                input logic [SW-1:0] slew);
        logic signed [DW:0] diff;
        logic signed [DW:0] mag;
        logic signed [DW:0] lim;
        logic signed [DW:0] step;
        logic signed [DW:0] sum;
        diff = $signed({goal[DW-1], goal}) - $signed({cur[DW-1], cur});
        mag  = diff[DW] ? -diff : diff;
        lim  = $signed({{(DW+1-SW){1'b0}}, slew});
        if (slew == '0 || mag <= lim) begin
            step = diff;
        end else begin
            step = diff[DW] ? -lim : lim;
        end
        sum = $signed({cur[DW-1], cur}) + step;
        return sum[DW-1:0];
    endfunction

    always_comb begin
        for (int n = 0; n < int'(NREG); n++) begin
            wr_sel[n] = lb_write && (lb_addr == BASE_ADDR + 15'(n));
        end
    end

    always_comb begin
        iq_d     = ~iq_q;
        state_d  = state_q;
        drive_d  = cur_q_q;
        cur_i_d  = cur_i_q;
        cur_q_d  = cur_q_q;
        tgt_i_d  = tgt_i_q;
        tgt_q_d  = tgt_q_q;
        slew_d   = slew_q;
        plen_d   = plen_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        trig_d   = trig_q;
        tick     = ~iq_q;
        run      = 1'b0;
        goal_i   = '0;
        goal_q   = '0;
        at_tgt   = 1'b0;
        at_zero  = 1'b0;
        trig_set = wr_sel[4] & lb_data[1] & lb_data[0];

        // Bus writes land in the registers; the FSM below always sees the pre-write values.
        if (wr_sel[0]) tgt_i_d = sym_clip(lb_data[DW-1:0]);
        if (wr_sel[1]) tgt_q_d = sym_clip(lb_data[DW-1:0]);
        if (wr_sel[2]) slew_d  = lb_data[SW-1:0];
        if (wr_sel[3]) plen_d  = lb_data[CW-1:0];
        if (wr_sel[4]) en_d    = lb_data[0];

        if (tick) begin
            run     = ((state_q == S_RAMP_UP) || (state_q == S_HOLD)) && en_q;
            goal_i  = run ? tgt_i_q : '0;
            goal_q  = run ? tgt_q_q : '0;
            cur_i_d = slew_step(cur_i_q, goal_i, slew_q);
            cur_q_d = slew_step(cur_q_q, goal_q, slew_q);
            drive_d = cur_i_d;
            at_tgt  = (cur_i_d == tgt_i_q) && (cur_q_d == tgt_q_q);
            at_zero = (cur_i_d == '0) && (cur_q_d == '0);
            trig_d  = trig_set;

            unique case (state_q)
                S_IDLE: begin
                    if (en_q && trig_q) begin
                        state_d = S_RAMP_UP;
                        cnt_d   = plen_q;
                    end
                end
                S_RAMP_UP: begin
                    if (!en_q) begin
                        state_d = S_RAMP_DOWN;
                    end else begin
                        if (trig_q) cnt_d = plen_q;
                        if (at_tgt) state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!en_q) begin
                        state_d = S_RAMP_DOWN;
                    end else begin
                        if (!at_tgt) state_d = S_RAMP_UP;
                        if (trig_q) begin
                            cnt_d = plen_q;
                        end else if (at_tgt && plen_q != '0) begin
                            if (cnt_q <= CW'(1)) begin
                                cnt_d   = '0;
                                state_d = S_RAMP_DOWN;
                            end else begin
                                cnt_d = cnt_q - CW'(1);
                            end
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (en_q && trig_q) begin
                        state_d = S_RAMP_UP;
                        cnt_d   = plen_q;
                    end else if (at_zero) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            trig_d = trig_q | trig_set;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iq_q    <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= '0;
            cur_i_q <= '0;
            cur_q_q <= '0;
            tgt_i_q <= '0;
            tgt_q_q <= '0;
            slew_q  <= '0;
            plen_q  <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iq_q    <= iq_d;
            busy_q  <= busy_d;
            drive_q <= drive_d;
            cur_i_q <= cur_i_d;
            cur_q_q <= cur_q_d;
            tgt_i_q <= tgt_i_d;
            tgt_q_q <= tgt_q_d;
            slew_q  <= slew_d;
            plen_q  <= plen_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            trig_q  <= trig_d;
        end
    end

    assign iq    = iq_q;
    assign drive = drive_q;
    assign state = state_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_iq_drive_gen.sv
// Bench for iq_drive_gen: integer reference model checked every cycle, directed scenarios
// with literal expectations, then randomized bus traffic and resets.
module tb_iq_drive_gen;

    localparam logic [14:0] BASE = 15'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lb_data = '0;
    logic [14:0] lb_addr = '0;
    logic        lb_write = 1'b0;
    logic        iq;
    logic [17:0] drive;
    logic [1:0]  st;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    iq_drive_gen #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .lb_data(lb_data), .lb_addr(lb_addr),
        .lb_write(lb_write), .iq(iq), .drive(drive), .state(st), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    int m_tgt_i, m_tgt_q, m_slew, m_plen, m_cnt, m_cur_i, m_cur_q, m_state, m_drive;
    bit m_en, m_trig, m_iq;

    function automatic int approach(input int cur, input int goal, input int slew);
        int d;
        d = goal - cur;
        if (slew == 0 || (d <= slew && d >= -slew)) return goal;
        return (d > 0) ? cur + slew : cur - slew;
    endfunction

    function automatic int tgt_of(input logic [31:0] d);
        int v;
        v = int'($signed(d[17:0]));
        return (v == -131072) ? -131071 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_tgt_i = 0; m_tgt_q = 0; m_slew = 0; m_plen = 0; m_cnt = 0;
            m_cur_i = 0; m_cur_q = 0; m_state = 0; m_drive = 0;
            m_en = 0; m_trig = 0; m_iq = 0;
        end else begin
            if (!m_iq) begin
                int gi, gq, ni, nq, ns, nc;
                bit run, at_t, at0;
                run  = (m_state == 1 || m_state == 2) && m_en;
                gi   = run ? m_tgt_i : 0;
                gq   = run ? m_tgt_q : 0;
                ni   = approach(m_cur_i, gi, m_slew);
                nq   = approach(m_cur_q, gq, m_slew);
                at_t = (ni == m_tgt_i) && (nq == m_tgt_q);
                at0  = (ni == 0) && (nq == 0);
                ns = m_state;
                nc = m_cnt;
                case (m_state)
                    0: if (m_en && m_trig) begin ns = 1; nc = m_plen; end
                    1, 2: begin
                        if (!m_en) ns = 3;
                        else begin
                            if (m_trig) nc = m_plen;
                            if (m_state == 1) begin
                                if (at_t) ns = 2;
                            end else if (!at_t) begin
                                ns = 1;
                            end else if (!m_trig && m_plen != 0) begin
                                nc = (m_cnt > 0) ? m_cnt - 1 : 0;
                                if (nc == 0) ns = 3;
                            end
                        end
                    end
                    default: begin
                        if (m_en && m_trig) begin ns = 1; nc = m_plen; end
                        else if (at0) ns = 0;
                    end
                endcase
                m_cur_i = ni; m_cur_q = nq; m_state = ns; m_cnt = nc;
                m_drive = ni;
                m_trig  = 0;
            end else begin
                m_drive = m_cur_q;
            end
            m_iq = !m_iq;
            if (lb_write) begin
                if (lb_addr == BASE + 15'd0) m_tgt_i = tgt_of(lb_data);
                if (lb_addr == BASE + 15'd1) m_tgt_q = tgt_of(lb_data);
                if (lb_addr == BASE + 15'd2) m_slew  = int'({16'b0, lb_data[15:0]});
                if (lb_addr == BASE + 15'd3) m_plen  = int'({8'b0, lb_data[23:0]});
                if (lb_addr == BASE + 15'd4) begin
                    m_en = lb_data[0];
                    if (lb_data[1] && lb_data[0]) m_trig = 1;
                end
            end
        end
    end

    // Compare process: every cycle against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("iq",    int'(iq),             int'(m_iq));
            check("drive", int'($signed(drive)), m_drive);
            check("state", int'(st),             m_state);
            check("busy",  int'(busy),           (m_state != 0) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wr(input int off, input int data);
        lb_addr  = 15'(BASE + 15'(off));
        lb_data  = 32'(data);
        lb_write = 1'b1;
        @(negedge clk);
        lb_write = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(st) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, int'(st), s);
    endtask

    initial begin
        int n;
        int q[$];
        int act;
        bit found;

        // 1: reset held 4 cycles
        rst = 1'b1;
        @(posedge clk);
        chk_on = 1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rst_iq",    int'(iq), k % 2);
            check("rst_drive", int'($signed(drive)), 0);
            check("rst_state", int'(st), 0);
            check("rst_busy",  int'(busy), 0);
            @(negedge clk);
        end

        // 2: unlimited slew, continuous hold
        wr(0, 50000); wr(1, -20000); wr(2, 0); wr(3, 0); wr(4, 3);
        wait_state(2, 20, "t2_hold");
        for (int k = 0; k < 4; k++) begin
            check("t2_slot", int'($signed(drive)), iq ? 50000 : -20000);
            @(negedge clk);
        end
        wr(4, 0);
        wait_state(0, 20, "t2_idle");
        check("t2_zero", int'($signed(drive)), 0);

        // 3: slew-limited ramp of I
        wr(2, 1000); wr(1, 0); wr(0, 10000); wr(4, 3);
        for (int k = 0; k < 60; k++) begin
            if (iq && $signed(drive) != 0) q.push_back(int'($signed(drive)));
            if (st == 2'd2) break;
            @(negedge clk);
        end
        check("t3_nsteps", q.size(), 10);
        for (int k = 0; k < 10; k++) begin
            act = (k < q.size()) ? q[k] : -1;
            check("t3_step", act, 1000 * (k + 1));
        end
        check("t3_hold", int'(st), 2);

        // 4: finite pulse length
        wr(4, 0);
        wait_state(0, 20, "t4_idle0");
        wr(3, 100); wr(2, 0); wr(4, 3);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            if (iq && st == 2'd2) n++;
            if (n > 0 && st == 2'd3) break;
            @(negedge clk);
        end
        check("t4_hold_ticks", n, 100);
        wait_state(0, 40, "t4_idle");
        check("t4_busy", int'(busy), 0);
        check("t4_drive", int'($signed(drive)), 0);

        // 5: enable cleared mid-ramp
        wr(3, 0); wr(2, 500); wr(0, 20000); wr(4, 3);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (iq && $signed(drive) == 6000) found = 1;
            else @(negedge clk);
        end
        check("t5_found6000", int'(found), 1);
        wr(4, 0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (iq) begin
                n++;
                if ($signed(drive) == 0) break;
            end
            @(negedge clk);
        end
        check("t5_down_ticks", n, 12);
        wait_state(0, 10, "t5_idle");

        // 6: symmetric clip, then reset mid-hold
        wr(0, 32'h0002_0000); wr(2, 0); wr(4, 3);
        wait_state(2, 20, "t6_hold");
        if (!iq) @(negedge clk);
        check("t6_clip", int'($signed(drive)), -131071);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_drive", int'($signed(drive)), 0);
        check("t6_rst_state", int'(st), 0);
        check("t6_rst_busy",  int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr(4, 3);
        wait_state(2, 20, "t6_rehold");
        for (int k = 0; k < 2; k++) begin
            check("t6_regs_zero", int'($signed(drive)), 0);
            @(negedge clk);
        end
        wr(4, 0);
        wait_state(0, 20, "t6_idle");

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                int off, v, junk, sel;
                off  = $urandom_range(0, 6);
                junk = int'($urandom());
                sel  = $urandom_range(0, 3);
                case (off)
                    0, 1: begin
                        case (sel)
                            0: v = int'($urandom_range(0, 262143));
                            1: v = 32'h0002_0000;
                            2: v = int'($urandom_range(0, 4000)) - 2000;
                            default: v = 0;
                        endcase
                        v = (junk & 32'hFFFC_0000) | (v & 32'h0003_FFFF);
                    end
                    2: begin
                        case (sel)
                            0: v = 0;
                            1: v = int'($urandom_range(1, 3000));
                            2: v = int'($urandom_range(3000, 65535));
                            default: v = int'($urandom_range(20000, 65535));
                        endcase
                        v = (junk & 32'hFFFF_0000) | v;
                    end
                    3: v = (junk & 32'hFF00_0000) | int'($urandom_range(0, 20));
                    4: begin
                        v = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(0, 2));
                        v = (junk & 32'hFFFF_FFFC) | v;
                    end
                    default: v = junk;
                endcase
                wr(off, v);
            end else begin
                @(negedge clk);
            end
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
